// File: rtl/lsu_mem_port_pkg.sv
// Shared codes, FSM states and the latched request
// bundle for the load/store memory port.
package lsu_mem_port_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_W    = 3'b011;
  localparam logic [2:0] LD_BU   = 3'b100;
  localparam logic [2:0] LD_HU   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BEAT0 = 2'b01,
    S_BEAT1 = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [2:0]  ctrl;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational sizing, lane masks, store shift and
// load extraction/extension for one access.
module lsu_align
  import lsu_mem_port_pkg::*;
(
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [2:0]  ctrl,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata,
  output logic        split,
  output logic [7:0]  mask,
  output logic [63:0] wdata64,
  output logic [31:0] ldata
);

  logic [2:0]  n;
  logic [7:0]  m;
  logic [31:0] wm;
  logic [31:0] sh;

  always_comb begin
    n = 3'd4;
    if (wr) begin
      case (size)
        SZ_B:    n = 3'd1;
        SZ_H:    n = 3'd2;
        default: n = 3'd4;
      endcase
    end else begin
      case (ctrl)
        LD_B, LD_BU: n = 3'd1;
        LD_H, LD_HU: n = 3'd2;
        default:     n = 3'd4;
      endcase
    end
  end

  assign split = ({2'b00, off} + {1'b0, n}) > 4'd4;

  assign m    = (8'd1 << n) - 8'd1;
  assign mask = m << off;

  always_comb begin
    wm = wdata;
    unique case (1'b1)
      (n == 3'd1): wm = {24'd0, wdata[7:0]};
      (n == 3'd2): wm = {16'd0, wdata[15:0]};
      default:     wm = wdata;
    endcase
  end

  assign wdata64 = {32'd0, wm} << {off, 3'b000};

  assign sh = 32'(rdata >> {off, 3'b000});

  always_comb begin
    ldata = sh;
    unique case (1'b1)
      (ctrl == LD_B):  ldata = {{24{sh[7]}}, sh[7:0]};
      (ctrl == LD_H):  ldata = {{16{sh[15]}}, sh[15:0]};
      (ctrl == LD_BU): ldata = {24'd0, sh[7:0]};
      (ctrl == LD_HU): ldata = {16'd0, sh[15:0]};
      default:         ldata = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store memory port: req/ack bus FSM with
// misaligned split into two beats and ack timeout.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_store_size,
  input  logic [2:0]  req_load_ctrl,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  state_t      nxt;
  lsu_req_t    r;
  logic [31:0] lo;
  logic [31:0] cnt;
  logic        terr;
  logic        tmo;
  logic        beat;
  logic        fin;
  logic        split;
  logic [7:0]  mask;
  logic [63:0] w64;
  logic [63:0] rd64;
  logic [31:0] ldata;
  logic [31:0] base;

  assign base = {r.addr[31:2], 2'b00};
  assign beat = (state == S_BEAT0) ||
                (state == S_BEAT1);

  assign rd64 = (state == S_BEAT1) ?
                {mem_rdata, lo} :
                {32'd0, mem_rdata};

  lsu_align u_align (
    .wr      (r.write),
    .size    (r.size),
    .ctrl    (r.ctrl),
    .off     (r.addr[1:0]),
    .wdata   (r.wdata),
    .rdata   (rd64),
    .split   (split),
    .mask    (mask),
    .wdata64 (w64),
    .ldata   (ldata)
  );

  // Timeout fires on the last permitted cycle so mem_req
  // is held for exactly ACK_TIMEOUT cycles.
  assign tmo = (ACK_TIMEOUT != 0) && beat &&
               !mem_ack &&
               (cnt == 32'(ACK_TIMEOUT - 1));

  always_comb begin
    nxt       = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_be    = 4'd0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) nxt = S_BEAT0;
      end
      S_BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = r.write;
        mem_addr  = base;
        mem_be    = mask[3:0];
        mem_wdata = w64[31:0];
        if (mem_ack)
          nxt = split ? S_BEAT1 : S_DONE;
        else if (tmo)
          nxt = S_DONE;
      end
      S_BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = r.write;
        mem_addr  = base + 32'd4;
        mem_be    = mask[7:4];
        mem_wdata = w64[63:32];
        if (mem_ack || tmo) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign fin   = beat && (nxt == S_DONE);
  assign err   = done && terr;
  // Reset gating keeps stall low while a held request
  // sits against the reset.
  assign stall = !reset &&
                 ((state == S_IDLE && req_valid) || beat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      r         <= '0;
      lo        <= 32'd0;
      cnt       <= 32'd0;
      terr      <= 1'b0;
      load_data <= 32'd0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && req_valid) begin
        r.write <= req_write;
        r.addr  <= req_addr;
        r.wdata <= req_wdata;
        r.size  <= req_store_size;
        r.ctrl  <= req_load_ctrl;
      end
      if (state != nxt)
        cnt <= 32'd0;
      else if (beat)
        cnt <= cnt + 32'd1;
      if (state == S_BEAT0 && mem_ack)
        lo <= mem_rdata;
      if (fin) begin
        terr <= tmo;
        if (tmo)
          load_data <= 32'd0;
        else if (!r.write)
          load_data <= ldata;
      end
    end
  end

endmodule
